// File: rtl/npu_pe_pkg.sv
// Shared types and arithmetic helpers for the weight-stationary PE.
// Product and saturation limits are computed wide, then narrowed by callers.
package npu_pe_pkg;

    typedef enum logic {
        W_EMPTY = 1'b0,
        W_READY = 1'b1
    } w_state_e;

    function automatic logic signed [127:0] sext_prod(
        input logic signed [63:0] a,
        input logic signed [63:0] b
    );
        return 128'(a) * 128'(b);
    endfunction

    function automatic logic [127:0] acc_max(input int w);
        return (128'(1) << (w - 1)) - 128'(1);
    endfunction

    function automatic logic [127:0] acc_min(input int w);
        return ~acc_max(w);
    endfunction

endpackage

// File: rtl/pe_ws_mac_if.sv
// Dataflow, weight-chain and status bundle for one PE.
// The slave side is the PE; the master side drives it.
interface pe_ws_mac_if #(
    parameter int DATA_W = 16,
    parameter int ACC_W  = 32
);
    logic              clr;
    logic [DATA_W-1:0] act_in;
    logic              act_vld_in;
    logic [DATA_W-1:0] act_out;
    logic              act_vld_out;
    logic [ACC_W-1:0]  psum_in;
    logic              psum_vld_in;
    logic [ACC_W-1:0]  psum_out;
    logic              psum_vld_out;
    logic [DATA_W-1:0] w_shift_in;
    logic              w_shift_en;
    logic [DATA_W-1:0] w_shift_out;
    logic              w_swap;
    logic              w_valid;
    logic              ovf;
    logic              err;

    modport master (
        output clr, act_in, act_vld_in, psum_in, psum_vld_in,
        output w_shift_in, w_shift_en, w_swap,
        input  act_out, act_vld_out, psum_out, psum_vld_out,
        input  w_shift_out, w_valid, ovf, err
    );

    modport slave (
        input  clr, act_in, act_vld_in, psum_in, psum_vld_in,
        input  w_shift_in, w_shift_en, w_swap,
        output act_out, act_vld_out, psum_out, psum_vld_out,
        output w_shift_out, w_valid, ovf, err
    );
endinterface

// File: rtl/pe_acc_add.sv
// Signed ACC_W adder with overflow flag.
// Build with SAT_ACC_EN to clamp on overflow; default wraps.
module pe_acc_add
    import npu_pe_pkg::*;
#(
    parameter int ACC_W = 32
) (
    input  logic [ACC_W-1:0] a,
    input  logic [ACC_W-1:0] b,
    output logic [ACC_W-1:0] sum,
    output logic             ovf
);
    logic [ACC_W:0] s;

    assign s   = {a[ACC_W-1], a} + {b[ACC_W-1], b};
    assign ovf = s[ACC_W] ^ s[ACC_W-1];

`ifdef SAT_ACC_EN
    // bit ACC_W carries the true sign of the sum
    always_comb begin
        sum = s[ACC_W-1:0];
        if (ovf)
            sum = s[ACC_W] ? ACC_W'(acc_min(ACC_W))
                           : ACC_W'(acc_max(ACC_W));
    end
`else
    assign sum = s[ACC_W-1:0];
`endif
endmodule

// File: rtl/pe_ws_mac.sv
// Weight-stationary systolic MAC cell with double-buffered weight.
// SAT_ACC_EN selects saturating accumulation (default: wrap).
module pe_ws_mac
    import npu_pe_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ACC_W  = 32
) (
    input  logic        clk,
    input  logic        rst,
    pe_ws_mac_if.slave  bus
);
    generate
        if (ACC_W < 2 * DATA_W) begin : g_wchk
            $error("pe_ws_mac: ACC_W must be >= 2*DATA_W");
        end
    endgenerate

    w_state_e          st, st_nx;
    logic [DATA_W-1:0] shadow, active, w_eff;
    logic [DATA_W-1:0] act_q;
    logic              act_vld_q;
    logic [ACC_W-1:0]  psum_q, prod, sum;
    logic              psum_vld_q, ovf_q, err_q;
    logic              mac, mism, sum_ovf;

    assign mac  = bus.act_vld_in & bus.psum_vld_in;
    assign mism = bus.act_vld_in ^ bus.psum_vld_in;

    // an empty PE contributes nothing, so psum passes through
    assign w_eff = (st == W_READY) ? active : '0;
    assign prod  = ACC_W'(sext_prod(64'(signed'(bus.act_in)),
                                    64'(signed'(w_eff))));

    pe_acc_add #(
        .ACC_W(ACC_W)
    ) u_add (
        .a   (bus.psum_in),
        .b   (prod),
        .sum (sum),
        .ovf (sum_ovf)
    );

    always_comb begin
        st_nx = st;
        if (bus.w_swap)
            st_nx = W_READY;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            st <= W_EMPTY;
        else
            st <= st_nx;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shadow     <= '0;
            active     <= '0;
            act_q      <= '0;
            act_vld_q  <= 1'b0;
            psum_q     <= '0;
            psum_vld_q <= 1'b0;
            ovf_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            if (bus.act_vld_in)
                act_q <= bus.act_in;
            act_vld_q <= bus.act_vld_in & ~bus.clr;
            if (mac)
                psum_q <= sum;
            psum_vld_q <= mac & ~bus.clr;
            ovf_q <= ~bus.clr & (ovf_q | (mac & sum_ovf));
            err_q <= ~bus.clr & (err_q | mism);
            if (bus.w_shift_en)
                shadow <= bus.w_shift_in;
            if (bus.w_swap)
                active <= shadow;
        end
    end

    assign bus.act_out      = act_q;
    assign bus.act_vld_out  = act_vld_q;
    assign bus.psum_out     = psum_q;
    assign bus.psum_vld_out = psum_vld_q;
    assign bus.w_shift_out  = shadow;
    assign bus.w_valid      = (st == W_READY);
    assign bus.ovf          = ovf_q;
    assign bus.err          = err_q;
endmodule
